// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_sram_slave
// Brief    : AXI3-style slave serving single-beat and burst traffic from a
//            single-port synchronous SRAM, one transaction in flight.
// Revision : 1.0 - initial release
// ============================================================================
module axi_sram_slave #(
    parameter int unsigned MEM_WORDS_LOG2 = 14,
    parameter logic [31:0] BASE_ADDR      = 32'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    // write address
    input  logic [3:0]                awid_i,
    input  logic [31:0]               awaddr_i,
    input  logic [3:0]                awlen_i,
    input  logic [2:0]                awsize_i,
    input  logic [1:0]                awburst_i,
    input  logic                      awvalid_i,
    output logic                      awready_o,
    // write data
    input  logic [31:0]               wdata_i,
    input  logic [3:0]                wstrb_i,
    input  logic                      wlast_i,
    input  logic                      wvalid_i,
    output logic                      wready_o,
    // write response
    output logic [3:0]                bid_o,
    output logic [1:0]                bresp_o,
    output logic                      bvalid_o,
    input  logic                      bready_i,
    // read address
    input  logic [3:0]                arid_i,
    input  logic [31:0]               araddr_i,
    input  logic [3:0]                arlen_i,
    input  logic [2:0]                arsize_i,
    input  logic [1:0]                arburst_i,
    input  logic                      arvalid_i,
    output logic                      arready_o,
    // read data
    output logic [3:0]                rid_o,
    output logic [31:0]               rdata_o,
    output logic [1:0]                rresp_o,
    output logic                      rlast_o,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    // SRAM
    output logic                      sram_en_o,
    output logic [3:0]                sram_we_o,
    output logic [MEM_WORDS_LOG2-1:0] sram_addr_o,
    output logic [31:0]               sram_wdata_o,
    input  logic [31:0]               sram_rdata_i
);

    localparam int unsigned c_WIN_LSB = MEM_WORDS_LOG2 + 2;
    localparam logic [1:0]  c_OKAY    = 2'b00;
    localparam logic [1:0]  c_SLVERR  = 2'b10;
    localparam logic [1:0]  c_FIXED   = 2'b00;
    localparam logic [2:0]  c_SIZE_32 = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_DATA = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_CAP  = 3'd4,
        S_RD_DATA = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        prio_read_q, prio_read_d;
    logic [3:0]  id_q, id_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [1:0]  burst_q, burst_d;
    logic [2:0]  size_q, size_d;
    logic [3:0]  beat_q, beat_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    logic        w_beat_ok;
    logic        w_last_beat;
    logic [31:0] w_next_addr;
    logic        w_awready;
    logic        w_arready;
    logic        w_wready;
    logic        w_bvalid;
    logic        w_rvalid;
    logic        w_sram_en;
    logic [3:0]  w_sram_we;
    logic [31:0] w_sram_wdata;

    assign w_beat_ok   = (addr_q[31:c_WIN_LSB] == BASE_ADDR[31:c_WIN_LSB]) &&
                         (size_q == c_SIZE_32);
    assign w_last_beat = (beat_q == len_q);
    // Every burst type other than FIXED steps by one word, wrapping at 2^32.
    assign w_next_addr = (burst_q == c_FIXED) ? addr_q : addr_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        prio_read_d  = prio_read_q;
        id_d         = id_q;
        addr_d       = addr_q;
        len_d        = len_q;
        burst_d      = burst_q;
        size_d       = size_q;
        beat_d       = beat_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        w_awready    = 1'b0;
        w_arready    = 1'b0;
        w_wready     = 1'b0;
        w_bvalid     = 1'b0;
        w_rvalid     = 1'b0;
        w_sram_en    = 1'b0;
        w_sram_we    = 4'h0;
        w_sram_wdata = 32'h0;

        case (state_q)
            S_IDLE: begin
                // With both channels requesting, exactly one ready is raised.
                w_arready = !awvalid_i || prio_read_q;
                w_awready = !arvalid_i || !prio_read_q;
                if (arvalid_i && w_arready) begin
                    id_d        = arid_i;
                    addr_d      = araddr_i;
                    len_d       = arlen_i;
                    burst_d     = arburst_i;
                    size_d      = arsize_i;
                    beat_d      = 4'd0;
                    err_d       = 1'b0;
                    prio_read_d = 1'b0;
                    state_d     = S_RD_ADDR;
                end else if (awvalid_i && w_awready) begin
                    id_d        = awid_i;
                    addr_d      = awaddr_i;
                    len_d       = awlen_i;
                    burst_d     = awburst_i;
                    size_d      = awsize_i;
                    beat_d      = 4'd0;
                    err_d       = 1'b0;
                    prio_read_d = 1'b1;
                    state_d     = S_WR_DATA;
                end
            end

            S_WR_DATA: begin
                w_wready = 1'b1;
                if (wvalid_i) begin
                    if (w_beat_ok) begin
                        w_sram_en    = 1'b1;
                        w_sram_we    = wstrb_i;
                        w_sram_wdata = wdata_i;
                    end
                    if (!w_beat_ok || (wlast_i != w_last_beat)) begin
                        err_d = 1'b1;
                    end
                    if (w_last_beat) begin
                        state_d = S_WR_RESP;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                        addr_d  = w_next_addr;
                    end
                end
            end

            S_WR_RESP: begin
                w_bvalid = 1'b1;
                if (bready_i) begin
                    state_d = S_IDLE;
                end
            end

            S_RD_ADDR: begin
                w_sram_en = w_beat_ok;
                state_d   = S_RD_CAP;
            end

            S_RD_CAP: begin
                rdata_d = w_beat_ok ? sram_rdata_i : 32'h0;
                rresp_d = w_beat_ok ? c_OKAY : c_SLVERR;
                state_d = S_RD_DATA;
            end

            S_RD_DATA: begin
                w_rvalid = 1'b1;
                if (rready_i) begin
                    if (w_last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                        addr_d  = w_next_addr;
                        state_d = S_RD_ADDR;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prio_read_q <= 1'b1;
            id_q        <= 4'h0;
            addr_q      <= 32'h0;
            len_q       <= 4'h0;
            burst_q     <= 2'b00;
            size_q      <= 3'b000;
            beat_q      <= 4'h0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
            rresp_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            prio_read_q <= prio_read_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            burst_q     <= burst_d;
            size_q      <= size_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
        end
    end

    // The reset state is IDLE, whose readies would otherwise be high.
    assign awready_o    = w_awready && !rst;
    assign arready_o    = w_arready && !rst;
    assign wready_o     = w_wready && !rst;

    assign bvalid_o     = w_bvalid;
    assign bid_o        = id_q;
    assign bresp_o      = err_q ? c_SLVERR : c_OKAY;

    assign rvalid_o     = w_rvalid;
    assign rid_o        = id_q;
    assign rdata_o      = rdata_q;
    assign rresp_o      = rresp_q;
    assign rlast_o      = w_rvalid && w_last_beat;

    assign sram_en_o    = w_sram_en;
    assign sram_we_o    = w_sram_we;
    assign sram_addr_o  = addr_q[MEM_WORDS_LOG2+1:2];
    assign sram_wdata_o = w_sram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_sram_slave
// Brief    : Self-checking bench for axi_sram_slave with an SRAM model and a
//            transaction-level reference of memory contents and responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave;

    localparam int          MEM_LOG2 = 14;
    localparam logic [31:0] BASE     = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awid = '0, awlen = '0, arid = '0, arlen = '0;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [1:0]  awburst = '0, arburst = '0;
    logic        awvalid = 1'b0, arvalid = 1'b0, awready, arready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0, wvalid = 1'b0, wready;
    logic [3:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready = 1'b1;
    logic [31:0] rdata;
    logic        rlast, rvalid, rready = 1'b0;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [MEM_LOG2-1:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata = '0;

    axi_sram_slave #(.MEM_WORDS_LOG2(MEM_LOG2), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize),
        .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid),
        .wready_o(wready),
        .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize),
        .arburst_i(arburst), .arvalid_i(arvalid), .arready_o(arready),
        .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
        .rvalid_o(rvalid), .rready_i(rready),
        .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rbeat_t;
    typedef struct { logic [MEM_LOG2-1:0] addr; logic [3:0] we; logic [31:0] data; } sw_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;

    rbeat_t exp_r[$], r_log[$];
    sw_t    exp_sw[$], sw_log[$];
    b_t     exp_b[$], b_log[$];

    logic [31:0] sram_mem [0:(1<<MEM_LOG2)-1];
    logic [31:0] ref_mem  [0:(1<<MEM_LOG2)-1];
    logic [3:0]  wr_strb  [16];
    logic [31:0] wr_data  [16];

    int n_checks = 0;
    int n_pass = 0;
    int rd_strobes = 0;
    int rr_mode = 0;   // 0 always ready, 1 random, 2 toggle, 3 never
    int br_mode = 0;   // 0 always ready, 1 random
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic bit beat_ok(input logic [31:0] a, input logic [2:0] size);
        return ((a >> (MEM_LOG2 + 2)) == (BASE >> (MEM_LOG2 + 2))) && (size == 3'd2);
    endfunction

    // SRAM: one-cycle read latency, byte-masked writes
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we == 4'h0) sram_rdata <= sram_mem[sram_addr];
            else for (int b = 0; b < 4; b++)
                if (sram_we[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    // Ready generators for the response channels
    initial forever begin
        @(posedge clk); #1;
        case (rr_mode)
            0: rready = 1'b1;
            1: rready = 1'($urandom % 2);
            2: rready = ~rready;
            default: rready = 1'b0;
        endcase
        bready = (br_mode == 0) ? 1'b1 : 1'($urandom % 2);
    end

    // Compare process: every cycle a response or an SRAM write strobe is visible
    always @(negedge clk) begin
        if (mon_en) begin
            if (rvalid) begin
                if (exp_r.size() == 0) begin
                    n_checks++;
                    $display("FAIL r_unexpected: got rvalid with data %0h, required none", rdata);
                end else begin
                    check("rdata", rdata, exp_r[0].data);
                    check("rresp", rresp, exp_r[0].resp);
                    check("rlast", rlast, exp_r[0].last);
                    check("rid", rid, exp_r[0].id);
                    if (rready) begin
                        r_log.push_back('{rdata, rresp, rlast, rid});
                        void'(exp_r.pop_front());
                    end
                end
            end
            if (bvalid) begin
                if (exp_b.size() == 0) begin
                    n_checks++;
                    $display("FAIL b_unexpected: got bvalid id %0h, required none", bid);
                end else begin
                    check("bid", bid, exp_b[0].id);
                    check("bresp", bresp, exp_b[0].resp);
                    if (bready) begin
                        b_log.push_back('{bid, bresp});
                        void'(exp_b.pop_front());
                    end
                end
            end
            if (sram_en && sram_we != 4'h0) begin
                if (exp_sw.size() == 0) begin
                    n_checks++;
                    $display("FAIL sw_unexpected: got write at %0h, required none", sram_addr);
                end else begin
                    check("sram_waddr", sram_addr, exp_sw[0].addr);
                    check("sram_we", sram_we, exp_sw[0].we);
                    check("sram_wdata", sram_wdata, exp_sw[0].data);
                    sw_log.push_back('{sram_addr, sram_we, sram_wdata});
                    void'(exp_sw.pop_front());
                end
            end
            if (sram_en && sram_we == 4'h0) rd_strobes++;
        end
    end

    task automatic push_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, output int n_ok);
        logic [31:0] a = addr;
        n_ok = 0;
        for (int i = 0; i <= int'(len); i++) begin
            bit ok = beat_ok(a, size);
            exp_r.push_back('{ok ? ref_mem[a[MEM_LOG2+1:2]] : 32'h0, ok ? 2'b00 : 2'b10, (i == int'(len)), id});
            if (ok) n_ok++;
            if (burst != 2'b00) a = a + 32'd4;
        end
    endtask

    task automatic ar_handshake(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                                input logic [2:0] size, input logic [1:0] burst);
        logic got = 1'b0;
        int t = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        do begin
            @(negedge clk); got = arready;
            @(posedge clk); #1; t++;
        end while (!got && t < 300);
        arvalid = 1'b0;
        if (!got) timeout_fail("ar_handshake");
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n_ok, s0, lat, t;
        push_read(id, addr, len, size, burst, n_ok);
        s0 = rd_strobes;
        ar_handshake(id, addr, len, size, burst);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rvalid && lat < 20);
        check("r_first_latency", lat, 3);
        t = 0;
        while (exp_r.size() != 0 && t < 1000) begin @(negedge clk); t++; end
        if (exp_r.size() != 0) begin timeout_fail("r_drain"); exp_r.delete(); end
        @(posedge clk); #1;
        check("sram_read_strobes", rd_strobes - s0, n_ok);
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int bad);
        logic [31:0] a = addr;
        bit err = 1'b0;
        logic got;
        int t;
        for (int i = 0; i <= int'(len); i++) begin
            if (beat_ok(a, size)) begin
                exp_sw.push_back('{a[MEM_LOG2+1:2], wr_strb[i], wr_data[i]});
                for (int b = 0; b < 4; b++)
                    if (wr_strb[i][b]) ref_mem[a[MEM_LOG2+1:2]][8*b +: 8] = wr_data[i][8*b +: 8];
            end else err = 1'b1;
            if (i == bad) err = 1'b1;
            if (burst != 2'b00) a = a + 32'd4;
        end
        exp_b.push_back('{id, err ? 2'b10 : 2'b00});
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clk); got = awready;
            @(posedge clk); #1; t++;
        end while (!got && t < 300);
        awvalid = 1'b0;
        if (!got) timeout_fail("aw_handshake");
        for (int i = 0; i <= int'(len); i++) begin
            repeat ($urandom % 3) begin @(posedge clk); #1; end
            wvalid = 1'b1; wdata = wr_data[i]; wstrb = wr_strb[i];
            wlast = (i == int'(len)) ^ (i == bad);
            t = 0;
            do begin
                @(negedge clk); got = wready;
                @(posedge clk); #1; t++;
            end while (!got && t < 100);
            wvalid = 1'b0; wlast = 1'b0;
            if (!got) timeout_fail("w_handshake");
        end
        t = 0;
        while (exp_b.size() != 0 && t < 200) begin @(negedge clk); t++; end
        if (exp_b.size() != 0) begin timeout_fail("b_drain"); exp_b.delete(); end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        int bad;

        for (int i = 0; i < (1 << MEM_LOG2); i++) begin
            sram_mem[i] = $urandom;
            ref_mem[i]  = sram_mem[i];
        end
        for (int i = 0; i < 16; i++) begin wr_strb[i] = 4'hF; wr_data[i] = $urandom; end

        // Reset: readies forced low even with requests pending
        awvalid = 1'b1; arvalid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_arready", arready, 0);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_sram_en", sram_en, 0);
        awvalid = 1'b0; arvalid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_arready", arready, 1);
        check("idle_awready", awready, 1);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Simultaneous AR/AW after reset: read wins
        wr_strb[0] = 4'hF; wr_data[0] = 32'h1234_5678;
        fork
            axi_read(4'd1, 32'h20, 4'd0, 3'd2, 2'b01);
            axi_write(4'd2, 32'h24, 4'd0, 3'd2, 2'b01, -1);
            begin
                @(negedge clk);
                check("arb1_arready", arready, 1);
                check("arb1_awready", awready, 0);
            end
        join
        // After a lone read, simultaneous requests favour the write
        axi_read(4'd5, 32'h30, 4'd0, 3'd2, 2'b01);
        fork
            axi_read(4'd6, 32'h34, 4'd0, 3'd2, 2'b01);
            axi_write(4'd7, 32'h38, 4'd0, 3'd2, 2'b01, -1);
            begin
                @(negedge clk);
                check("arb2_arready", arready, 0);
                check("arb2_awready", awready, 1);
            end
        join

        // Single write of 0xDEADBEEF to byte address 0x10
        sw_log.delete(); b_log.delete();
        wr_strb[0] = 4'hF; wr_data[0] = 32'hDEAD_BEEF;
        axi_write(4'd3, 32'h10, 4'd0, 3'd2, 2'b01, -1);
        check("t1_sw_count", sw_log.size(), 1);
        check("t1_b_count", b_log.size(), 1);
        if (sw_log.size() >= 1 && b_log.size() >= 1) begin
            check("t1_sram_addr", sw_log[0].addr, 4);
            check("t1_sram_we", sw_log[0].we, 4'hF);
            check("t1_sram_wdata", sw_log[0].data, 32'hDEAD_BEEF);
            check("t1_bid", b_log[0].id, 3);
            check("t1_bresp", b_log[0].resp, 0);
        end

        // INCR burst of four with rready toggling
        for (int i = 4; i < 8; i++) begin
            sram_mem[i] = 32'hA000_0000 + i;
            ref_mem[i]  = 32'hA000_0000 + i;
        end
        r_log.delete();
        rr_mode = 2;
        axi_read(4'd4, 32'h10, 4'd3, 3'd2, 2'b01);
        check("t2_beats", r_log.size(), 4);
        if (r_log.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                check("t2_rdata", r_log[i].data, 32'hA000_0004 + i);
                check("t2_rlast", r_log[i].last, (i == 3));
                check("t2_rresp", r_log[i].resp, 0);
            end

        // Read outside the window
        r_log.delete();
        rr_mode = 1;
        axi_read(4'd8, 32'h8000_0000, 4'd1, 3'd2, 2'b01);
        check("t4_beats", r_log.size(), 2);
        if (r_log.size() >= 2)
            for (int i = 0; i < 2; i++) begin
                check("t4_rdata", r_log[i].data, 0);
                check("t4_rresp", r_log[i].resp, 2'b10);
            end

        // FIXED write burst with a missing wlast
        sw_log.delete(); b_log.delete();
        wr_strb[0] = 4'h3; wr_data[0] = 32'h1111_2222;
        wr_strb[1] = 4'hC; wr_data[1] = 32'h3333_4444;
        axi_write(4'd9, 32'h40, 4'd1, 3'd2, 2'b00, 1);
        check("t5_sw_count", sw_log.size(), 2);
        if (sw_log.size() >= 2 && b_log.size() >= 1) begin
            check("t5_addr0", sw_log[0].addr, 14'h10);
            check("t5_addr1", sw_log[1].addr, 14'h10);
            check("t5_we0", sw_log[0].we, 4'h3);
            check("t5_we1", sw_log[1].we, 4'hC);
            check("t5_bresp", b_log[0].resp, 2'b10);
        end

        // Reset in the middle of a read burst
        begin
            int n_ok, t;
            rr_mode = 3;
            push_read(4'd11, 32'h100, 4'd7, 3'd2, 2'b01, n_ok);
            ar_handshake(4'd11, 32'h100, 4'd7, 3'd2, 2'b01);
            t = 0;
            do begin @(negedge clk); t++; end while (!rvalid && t < 20);
            if (!rvalid) timeout_fail("t6_rvalid");
            @(posedge clk); #2;
            mon_en = 1'b0;
            rst = 1'b1;
            #1;
            check("t6_rvalid_in_rst", rvalid, 0);
            check("t6_sram_en_in_rst", sram_en, 0);
            check("t6_arready_in_rst", arready, 0);
            exp_r.delete();
            @(posedge clk); #1;
            rst = 1'b0;
            mon_en = 1'b1;
            rr_mode = 1;
            axi_read(4'd10, 32'h200, 4'd0, 3'd2, 2'b01);
        end

        // Randomized traffic
        br_mode = 1;
        for (int k = 0; k < 60; k++) begin
            case ($urandom % 10)
                0:       addr = 32'hFFFF_FFF8;
                1:       addr = 32'h8000_0000 | ($urandom % 256);
                default: addr = BASE | (($urandom % 128) << 2) | ($urandom % 4);
            endcase
            len  = 4'($urandom % 16);
            size = ($urandom % 8 == 0) ? 3'($urandom % 8) : 3'd2;
            if ($urandom % 2 == 0) begin
                axi_read(4'($urandom), addr, len, size, 2'($urandom % 4));
            end else begin
                for (int i = 0; i < 16; i++) begin
                    wr_strb[i] = 4'($urandom_range(1, 15));
                    wr_data[i] = $urandom;
                end
                bad = ($urandom % 6 == 0) ? int'($urandom % (int'(len) + 1)) : -1;
                axi_write(4'($urandom), addr, len, size, 2'($urandom % 4), bad);
            end
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
